input_event_scheduler: RTL and testbench
========================================

// Module: input_event_scheduler
// PURPOSE
//  Collects rising/falling edge strobes from NUM_CH glitch-filtered, synchronized inputs.
//  Holds one pending event per channel and round-robin arbitrates them onto a single
//  valid/ready event port, which feeds the PFR bypass event handler / logger.
//  Flags channels whose pending event is overwritten before it is serviced.
// PARAMETERS
//  NUM_CH    8   number of filtered input channels (2..32)
//  TS_WIDTH  16  timestamp counter width (used only with EVENT_TIMESTAMP_EN)
// PORTS
//  clock              in   1         master clock, same domain as the edge strobes
//  i_resetn           in   1         asynchronous active-low reset
//  i_rising_edge      in   NUM_CH    per-channel 1-cycle rising-edge strobe
//  i_falling_edge     in   NUM_CH    per-channel 1-cycle falling-edge strobe
//  i_chan_mask        in   NUM_CH    1 = channel disabled (edges ignored, pending dropped)
//  o_evt_valid        out  1         event presented
//  i_evt_ready        in   1         consumer accepts event when valid & ready
//  o_evt_chan         out  CH_IDX_W  channel index of the presented event
//  o_evt_level        out  1         1 = rising edge (new level high), 0 = falling edge
//  o_evt_timestamp    out  TS_WIDTH  edge capture time (present only with EVENT_TIMESTAMP_EN)
//  o_overrun          out  NUM_CH    sticky: pending event overwritten before grant
//  i_clear_overrun    in   NUM_CH    1-cycle pulse clears the matching o_overrun bits
// BEHAVIOUR
//  Reset: all outputs are 0. Pending flags are 0, the RR pointer is 0, and the FSM is IDLE.
//  Per-channel pending: {pend_v, pend_lvl}. A rising edge loads lvl=1; a falling edge loads lvl=0.
//  Both strobes on the same cycle: treated as a falling edge (lvl=0). This is illegal from the
//    filter and is flagged by an assertion.
//  Edge while pend_v=1 and the channel is not being granted on that cycle:
//    overwrite pend_lvl and set o_overrun[ch].
//  Edge on the same cycle as that channel's grant: the granted event goes out, the new edge
//    becomes pending, and no overrun is flagged.
//  Set and clear of o_overrun on the same cycle: set wins.
//  Mask: i_chan_mask[ch]=1 clears pend_v[ch] next cycle and blocks capture. An event already
//    in PRESENT is unaffected.
//  FSM, two states:
//    IDLE: if any (pend_v & ~mask), grant the first such channel at or after rr_ptr (wrapping
//      NUM_CH-1 -> 0). Load o_evt_* and clear that pend_v. Set rr_ptr = grant+1 (mod NUM_CH).
//      Go to PRESENT with o_evt_valid=1.
//    PRESENT: o_evt_* held stable. When i_evt_ready=1, drop o_evt_valid and return to IDLE.
//  Latency: strobe at cycle t -> pend_v at t+1 -> o_evt_valid at t+2 (FSM idle, no contention).
//  Throughput: one event per 2 cycles (IDLE bubble between grants).
//  CH_IDX_W = (NUM_CH>1) ? $clog2(NUM_CH) : 1.
//  Reset asserted mid-operation: pending events and overrun flags are lost. The bench
//    resynchronises by reading the current levels.
// CONFIGURATION
//  Macro EVENT_TIMESTAMP_EN:
//    Defined: a free-running TS_WIDTH counter (wraps at 2^TS_WIDTH-1 -> 0, reset to 0) is
//      captured into a per-channel register on each accepted edge. On overwrite, the newer
//      time is kept. The value is output on o_evt_timestamp with the event.
//    Undefined: no counter, no per-channel timestamp storage, and the o_evt_timestamp port
//      does not exist.
// STRUCTURE
//  Package pfr_input_evt_pkg:
//    typedef enum logic {EVT_IDLE, EVT_PRESENT} evt_state_t;
//    EVT_LVL_RISE = 1'b1, EVT_LVL_FALL = 1'b0;
//    typedef struct packed {chan, lvl} evt_t, parameterised via package function widths.
//  Sub-module rr_arbiter #(N): inputs req[N] and ptr; outputs one-hot gnt, gnt_idx and any.
//    Purely combinational. Reused by other PFR schedulers.
// TESTING
//  1. Reset, rising strobe ch3 at t, ready=1
//     -> valid at t+2, chan=3, lvl=1, accepted at t+2, valid=0 at t+3.
//  2. Strobes ch0,ch5,ch7 same cycle, ptr=0, ready=1
//     -> events ch0, ch5, ch7 on cycles t+2, t+4, t+6; ptr ends at 0.
//  3. ready=0 while ch2 rises, then ch4 rises, then ch4 falls
//     -> ch2 held stable. o_overrun[4]=1. After ready, ch4 is delivered with lvl=0.
//  4. ch1 edge on the same cycle ch1 is granted
//     -> both events delivered in order, o_overrun[1]=0.
//  5. Mask ch6 with pending event
//     -> never presented. Unmask, then an edge -> delivered normally.
//     Clear_overrun coincident with a new overrun -> bit stays 1.
//  6. EVENT_TIMESTAMP_EN, counter near wrap (0xFFFE)
//     -> timestamps 0xFFFE and 0x0001 reported for edges 3 cycles apart.

Source files
------------

// File: rtl/pfr_input_evt_pkg.sv
// Shared types and helpers for the PFR input event scheduler and its arbiter.
package pfr_input_evt_pkg;

    typedef enum logic {
        EVT_IDLE    = 1'b0,
        EVT_PRESENT = 1'b1
    } evt_state_t;

    localparam logic EVT_LVL_RISE = 1'b1;
    localparam logic EVT_LVL_FALL = 1'b0;

    // Index width for n channels; a single channel still needs one bit.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int EVT_MAX_CH = 32;
    localparam int EVT_CHAN_W = ch_idx_w(EVT_MAX_CH);

    typedef struct packed {
        logic [EVT_CHAN_W-1:0] chan;
        logic                  lvl;
    } evt_t;

endpackage

// File: rtl/input_event_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr,
// wrapping from N-1 back to 0.
module rr_arbiter
    import pfr_input_evt_pkg::*;
#(
    parameter  int N  = 8,
    localparam int IW = ch_idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    logic [IW-1:0] idx;

    // Walk the channels starting at ptr and latch onto the first requester.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            idx = IW'((int'(ptr) + i) % N);
            if (!any && req[idx]) begin
                any          = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = idx;
            end
        end
    end

endmodule

// File: rtl/input_event_scheduler.sv
// Input event scheduler: one pending edge event per channel, round-robin
// arbitrated onto a single valid/ready port, with sticky overrun flags.
// Optional feature macro: EVENT_TIMESTAMP_EN adds per-event capture timestamps.
module input_event_scheduler
    import pfr_input_evt_pkg::*;
#(
    parameter  int NUM_CH   = 8,
    parameter  int TS_WIDTH = 16,
    localparam int CH_IDX_W = ch_idx_w(NUM_CH)
) (
    input  logic                clock,
    input  logic                i_resetn,
    input  logic [NUM_CH-1:0]   i_rising_edge,
    input  logic [NUM_CH-1:0]   i_falling_edge,
    input  logic [NUM_CH-1:0]   i_chan_mask,
    output logic                o_evt_valid,
    input  logic                i_evt_ready,
    output logic [CH_IDX_W-1:0] o_evt_chan,
    output logic                o_evt_level,
`ifdef EVENT_TIMESTAMP_EN
    output logic [TS_WIDTH-1:0] o_evt_timestamp,
`endif
    output logic [NUM_CH-1:0]   o_overrun,
    input  logic [NUM_CH-1:0]   i_clear_overrun
);

    evt_state_t            state_q, state_d;
    logic [CH_IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CH_IDX_W-1:0]   chan_q, chan_d;
    logic                  lvl_q, lvl_d;
    logic [NUM_CH-1:0]     pend_v_q, pend_v_d;
    logic [NUM_CH-1:0]     pend_lvl_q, pend_lvl_d;
    logic [NUM_CH-1:0]     overrun_q, overrun_d;
    logic [NUM_CH-1:0]     req, gnt, gnt_fire, cap_edge, ovr_set;
    logic [CH_IDX_W-1:0]   gnt_idx;
    logic                  any_req, grant_fire;

    assign req = pend_v_q & ~i_chan_mask;

    rr_arbiter #(.N(NUM_CH)) u_arb (
        .req     (req),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any_req)
    );

    // Event FSM: grant from IDLE, hold the event stable in PRESENT until accepted.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        chan_d     = chan_q;
        lvl_d      = lvl_q;
        grant_fire = 1'b0;
        case (state_q)
            EVT_IDLE: begin
                if (any_req) begin
                    grant_fire = 1'b1;
                    chan_d     = gnt_idx;
                    lvl_d      = pend_lvl_q[gnt_idx];
                    rr_ptr_d   = (gnt_idx == CH_IDX_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
                    state_d    = EVT_PRESENT;
                end
            end
            EVT_PRESENT: begin
                if (i_evt_ready) begin
                    state_d = EVT_IDLE;
                end
            end
            default: state_d = EVT_IDLE;
        endcase
    end

    // Pending slots: a new edge always wins over the grant clearing the slot;
    // both strobes at once count as a falling edge.
    always_comb begin
        gnt_fire   = gnt & {NUM_CH{grant_fire}};
        cap_edge   = (i_rising_edge | i_falling_edge) & ~i_chan_mask;
        ovr_set    = cap_edge & pend_v_q & ~gnt_fire;
        pend_v_d   = (cap_edge | (pend_v_q & ~gnt_fire)) & ~i_chan_mask;
        overrun_d  = (overrun_q & ~i_clear_overrun) | ovr_set;
        pend_lvl_d = pend_lvl_q;
        for (int c = 0; c < NUM_CH; c++) begin
            if (cap_edge[c]) begin
                pend_lvl_d[c] = i_falling_edge[c] ? EVT_LVL_FALL : EVT_LVL_RISE;
            end
        end
    end

    // State, pointer, presented event, pending slots and overrun flags.
    always_ff @(posedge clock or negedge i_resetn) begin
        if (!i_resetn) begin
            state_q    <= EVT_IDLE;
            rr_ptr_q   <= '0;
            chan_q     <= '0;
            lvl_q      <= 1'b0;
            pend_v_q   <= '0;
            pend_lvl_q <= '0;
            overrun_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            chan_q     <= chan_d;
            lvl_q      <= lvl_d;
            pend_v_q   <= pend_v_d;
            pend_lvl_q <= pend_lvl_d;
            overrun_q  <= overrun_d;
        end
    end

    assign o_evt_valid = (state_q == EVT_PRESENT);
    assign o_evt_chan  = chan_q;
    assign o_evt_level = lvl_q;
    assign o_overrun   = overrun_q;

`ifdef EVENT_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_q;
    logic [TS_WIDTH-1:0] evt_ts_q;
    logic [TS_WIDTH-1:0] pend_ts_q [NUM_CH];

    // Free-running time base, per-channel capture (newest edge kept) and event copy.
    always_ff @(posedge clock or negedge i_resetn) begin
        if (!i_resetn) begin
            ts_q     <= '0;
            evt_ts_q <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                pend_ts_q[c] <= '0;
            end
        end else begin
            ts_q <= ts_q + 1'b1;
            if (grant_fire) begin
                evt_ts_q <= pend_ts_q[gnt_idx];
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (cap_edge[c]) begin
                    pend_ts_q[c] <= ts_q;
                end
            end
        end
    end

    assign o_evt_timestamp = evt_ts_q;
`endif

    // The edge filter never produces both strobes on one channel in one cycle.
    always @(posedge clock) begin
        if (i_resetn) begin
            assert ((i_rising_edge & i_falling_edge) == '0);
        end
    end

    // Configuration sanity: supported channel counts and a non-empty time base.
    always @(posedge clock) begin
        assert ((NUM_CH >= 2) && (NUM_CH <= 32) && (TS_WIDTH >= 1));
    end

endmodule

// File: tb/tb_input_event_scheduler.sv
// Self-checking bench for input_event_scheduler: directed scenarios followed by
// randomized traffic, all compared every cycle against a behavioural model.
module tb_input_event_scheduler;

   localparam int NUM_CH   = 8;
   localparam int TS_WIDTH = 16;
   localparam int CH_IDX_W = 3;

   logic                clock = 1'b0;
   logic                i_resetn;
   logic [NUM_CH-1:0]   i_rising_edge, i_falling_edge, i_chan_mask, i_clear_overrun;
   logic                i_evt_ready;
   logic                o_evt_valid, o_evt_level;
   logic [CH_IDX_W-1:0] o_evt_chan;
   logic [NUM_CH-1:0]   o_overrun;
`ifdef EVENT_TIMESTAMP_EN
   logic [TS_WIDTH-1:0] o_evt_timestamp;
`endif

   int checkCount = 0;
   int errorCount = 0;
   logic [NUM_CH-1:0] curMask = '0;

   // Behavioural model of the scheduler's observable state
   bit          mPendV   [NUM_CH];
   bit          mPendLvl [NUM_CH];
   int unsigned mPendTs  [NUM_CH];
   bit [NUM_CH-1:0] mOverrun;
   bit          mPresent;
   int          mChan;
   bit          mLvl;
   int unsigned mEvtTs;
   int          mPtr;
   int unsigned mTime;

   always #5 clock = ~clock;

   input_event_scheduler #(.NUM_CH(NUM_CH), .TS_WIDTH(TS_WIDTH)) dut (
      .clock           (clock),
      .i_resetn        (i_resetn),
      .i_rising_edge   (i_rising_edge),
      .i_falling_edge  (i_falling_edge),
      .i_chan_mask     (i_chan_mask),
      .o_evt_valid     (o_evt_valid),
      .i_evt_ready     (i_evt_ready),
      .o_evt_chan      (o_evt_chan),
      .o_evt_level     (o_evt_level),
`ifdef EVENT_TIMESTAMP_EN
      .o_evt_timestamp (o_evt_timestamp),
`endif
      .o_overrun       (o_overrun),
      .i_clear_overrun (i_clear_overrun)
   );

   // Single comparison point: counts every check and reports any difference
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic modelReset();
      for (int c = 0; c < NUM_CH; c++) begin
         mPendV[c] = 1'b0; mPendLvl[c] = 1'b0; mPendTs[c] = 0;
      end
      mOverrun = '0; mPresent = 1'b0; mChan = 0; mLvl = 1'b0;
      mEvtTs = 0; mPtr = 0; mTime = 0;
   endtask

   // One clock of the scheduler rules, using the inputs present at the edge
   task automatic modelStep();
      int g;
      bit [NUM_CH-1:0] newOv;
      g = -1;
      newOv = '0;
      if (!mPresent) begin
         for (int k = 0; k < NUM_CH; k++) begin
            int c;
            c = (mPtr + k) % NUM_CH;
            if (g < 0 && mPendV[c] && !i_chan_mask[c]) g = c;
         end
      end
      if (mPresent) begin
         if (i_evt_ready) mPresent = 1'b0;
      end else if (g >= 0) begin
         mPresent = 1'b1;
         mChan    = g;
         mLvl     = mPendLvl[g];
         mEvtTs   = mPendTs[g];
         mPtr     = (g + 1) % NUM_CH;
      end
      for (int c = 0; c < NUM_CH; c++) begin
         if (i_chan_mask[c]) begin
            mPendV[c] = 1'b0;
         end else if (i_rising_edge[c] || i_falling_edge[c]) begin
            if (mPendV[c] && c != g) newOv[c] = 1'b1;
            mPendV[c]   = 1'b1;
            mPendLvl[c] = !i_falling_edge[c];
            mPendTs[c]  = mTime;
         end else if (c == g) begin
            mPendV[c] = 1'b0;
         end
      end
      mOverrun = (mOverrun & ~i_clear_overrun) | newOv;
      mTime    = (mTime + 1) % (1 << TS_WIDTH);
   endtask

   task automatic compareAll();
      checkOutput("valid", 32'(o_evt_valid), 32'(mPresent));
      if (mPresent) begin
         checkOutput("chan", 32'(o_evt_chan), 32'(mChan));
         checkOutput("level", 32'(o_evt_level), 32'(mLvl));
`ifdef EVENT_TIMESTAMP_EN
         checkOutput("timestamp", 32'(o_evt_timestamp), mEvtTs);
`endif
      end
      checkOutput("overrun", 32'(o_overrun), 32'(mOverrun));
   endtask

   // Drive one cycle of inputs, advance model and DUT together, then compare
   task automatic applyStimulus(input logic [NUM_CH-1:0] rise, input logic [NUM_CH-1:0] fall,
                                input logic [NUM_CH-1:0] mask, input logic rdy,
                                input logic [NUM_CH-1:0] clr);
      i_rising_edge   = rise;
      i_falling_edge  = fall;
      i_chan_mask     = mask;
      i_evt_ready     = rdy;
      i_clear_overrun = clr;
      @(posedge clock);
      modelStep();
      #1;
      compareAll();
   endtask

   task automatic idle(input int n, input logic rdy);
      repeat (n) applyStimulus('0, '0, curMask, rdy, '0);
   endtask

   task automatic doReset();
      i_resetn = 1'b0;
      i_rising_edge = '0; i_falling_edge = '0; i_chan_mask = '0;
      i_evt_ready = 1'b0; i_clear_overrun = '0;
      curMask = '0;
      #1;
      checkOutput("rst_valid", 32'(o_evt_valid), 32'd0);
      checkOutput("rst_chan", 32'(o_evt_chan), 32'd0);
      checkOutput("rst_level", 32'(o_evt_level), 32'd0);
      checkOutput("rst_overrun", 32'(o_overrun), 32'd0);
      modelReset();
      repeat (2) @(posedge clock);
      @(negedge clock);
      i_resetn = 1'b1;
   endtask

   initial begin
      int q[$];
      bit sawCh6;
      logic [NUM_CH-1:0] rise, fall, clr;

      doReset();

      // Single rising edge on ch3: presented two cycles after the strobe
      applyStimulus(8'h08, '0, '0, 1'b1, '0);
      applyStimulus('0, '0, '0, 1'b1, '0);
      checkOutput("t1_valid", 32'(o_evt_valid), 32'd1);
      checkOutput("t1_chan", 32'(o_evt_chan), 32'd3);
      checkOutput("t1_level", 32'(o_evt_level), 32'd1);
      applyStimulus('0, '0, '0, 1'b1, '0);
      checkOutput("t1_drop", 32'(o_evt_valid), 32'd0);

      // Three simultaneous strobes served in round-robin order from ptr 0
      doReset();
      applyStimulus(8'hA1, '0, '0, 1'b1, '0);
      for (int i = 0; i < 7; i++) begin
         applyStimulus('0, '0, '0, 1'b1, '0);
         if (o_evt_valid) q.push_back(int'(o_evt_chan));
      end
      checkOutput("t2_count", 32'(q.size()), 32'd3);
      checkOutput("t2_first", 32'((q.size() > 0) ? q[0] : 99), 32'd0);
      checkOutput("t2_second", 32'((q.size() > 1) ? q[1] : 99), 32'd5);
      checkOutput("t2_third", 32'((q.size() > 2) ? q[2] : 99), 32'd7);
      applyStimulus(8'h81, '0, '0, 1'b1, '0);
      applyStimulus('0, '0, '0, 1'b1, '0);
      checkOutput("t2_wrap_ptr", 32'(o_evt_chan), 32'd0);
      idle(4, 1'b1);

      // Stalled consumer: ch4 rises then falls while ch2 is held
      applyStimulus(8'h04, '0, '0, 1'b0, '0);
      applyStimulus('0, '0, '0, 1'b0, '0);
      applyStimulus(8'h10, '0, '0, 1'b0, '0);
      applyStimulus('0, 8'h10, '0, 1'b0, '0);
      checkOutput("t3_hold_chan", 32'(o_evt_chan), 32'd2);
      checkOutput("t3_overrun4", 32'(o_overrun[4]), 32'd1);
      applyStimulus('0, '0, '0, 1'b1, '0);
      applyStimulus('0, '0, '0, 1'b1, '0);
      checkOutput("t3_chan4", 32'(o_evt_chan), 32'd4);
      checkOutput("t3_level4", 32'(o_evt_level), 32'd0);
      idle(3, 1'b1);

      // Edge arriving on the same cycle its channel is granted
      applyStimulus(8'h02, '0, '0, 1'b1, '0);
      applyStimulus('0, 8'h02, '0, 1'b1, '0);
      checkOutput("t4_first_lvl", 32'(o_evt_level), 32'd1);
      applyStimulus('0, '0, '0, 1'b1, '0);
      applyStimulus('0, '0, '0, 1'b1, '0);
      checkOutput("t4_second_chan", 32'(o_evt_chan), 32'd1);
      checkOutput("t4_second_lvl", 32'(o_evt_level), 32'd0);
      checkOutput("t4_no_overrun1", 32'(o_overrun[1]), 32'd0);
      idle(3, 1'b1);

      // Masked pending event is dropped; unmasked edge later flows normally
      sawCh6 = 1'b0;
      applyStimulus(8'h04, '0, '0, 1'b0, '0);
      applyStimulus('0, '0, '0, 1'b0, '0);
      applyStimulus(8'h40, '0, '0, 1'b0, '0);
      applyStimulus('0, '0, 8'h40, 1'b0, '0);
      applyStimulus('0, '0, 8'h40, 1'b1, '0);
      for (int i = 0; i < 6; i++) begin
         applyStimulus('0, '0, '0, 1'b1, '0);
         if (o_evt_valid && o_evt_chan == 3'd6) sawCh6 = 1'b1;
      end
      checkOutput("t5_masked_ch6", 32'(sawCh6), 32'd0);
      applyStimulus(8'h40, '0, '0, 1'b1, '0);
      applyStimulus('0, '0, '0, 1'b1, '0);
      checkOutput("t5_unmasked_ch6", 32'(o_evt_chan), 32'd6);
      idle(3, 1'b1);

      // Clear coincident with a fresh overrun keeps the flag set
      applyStimulus(8'h04, '0, '0, 1'b0, '0);
      applyStimulus('0, '0, '0, 1'b0, '0);
      applyStimulus(8'h20, '0, '0, 1'b0, '0);
      applyStimulus(8'h20, '0, '0, 1'b0, '0);
      applyStimulus('0, 8'h20, '0, 1'b0, 8'h20);
      checkOutput("t5_set_wins", 32'(o_overrun[5]), 32'd1);
      applyStimulus('0, '0, '0, 1'b0, 8'h20);
      checkOutput("t5_cleared", 32'(o_overrun[5]), 32'd0);
      idle(8, 1'b1);

`ifdef EVENT_TIMESTAMP_EN
      // Timestamps across the counter wrap
      for (int i = 0; i < 70000 && mTime != 32'hFFFE; i++) idle(1, 1'b1);
      applyStimulus(8'h04, '0, '0, 1'b1, '0);
      idle(2, 1'b1);
      checkOutput("t6_ts_fffe", 32'(o_evt_timestamp), 32'hFFFE);
      applyStimulus(8'h08, '0, '0, 1'b1, '0);
      idle(1, 1'b1);
      checkOutput("t6_ts_0001", 32'(o_evt_timestamp), 32'h0001);
      idle(3, 1'b1);
`endif

      // Randomized traffic with an asynchronous reset in the middle
      for (int n = 0; n < 3000; n++) begin
         if (n == 1500) doReset();
         for (int c = 0; c < NUM_CH; c++) begin
            rise[c] = ($urandom_range(7) == 0);
            fall[c] = !rise[c] && ($urandom_range(7) == 0);
            clr[c]  = ($urandom_range(15) == 0);
         end
         if ($urandom_range(49) == 0) begin
            curMask = '0;
            for (int c = 0; c < NUM_CH; c++) curMask[c] = ($urandom_range(3) == 0);
         end
         applyStimulus(rise, fall, curMask, ($urandom_range(9) < 6), clr);
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
